dw_reg_array: RTL and testbench
===============================

Name: dw_reg_array

Overview:
- Pixel register array sitting directly downstream of the buffer interface and upstream of the depthwise PE (dwpe).
- Holds POY lane registers, one per output row, and executes the per-lane reg_array_cmd issued by the buffer interface.
- Contains a reuse FIFO holding overlapping rows for the next window; its pops are driven by fifo_read.
- Presents the lane registers plus a valid strobe to the dwpe.

Parameters:
- DW, 8, pixel data width in bits.
- POY, 3, number of lanes (output rows); must be >= 2.
- FDEPTH, 16, reuse FIFO depth in entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high. One clock; all state resets on the rising edge with rst=1.
- buf_din  input  POY*DW  pixel data from the input buffer; lane i is bits [i*DW +: DW].
- reg_array_cmd  input  2*POY  per-lane command; lane i is bits [2i +: 2]. 00=IB, 01=SF, 10=IF, 11=NE.
- fifo_read  input  1  one-cycle pop request for the reuse FIFO.
- dwpe_ena  input  1  dwpe enable from the buffer interface.
- pix_out  output  POY*DW  lane registers to the dwpe; lane i is bits [i*DW +: DW].
- pix_vld  output  1  pix_out holds a freshly updated window.
- fifo_full  output  1  reuse FIFO count == FDEPTH.
- fifo_empty  output  1  reuse FIFO count == 0.
- ovf_err  output  1  sticky: push was attempted while the FIFO was full.
- udf_err  output  1  sticky: pop was attempted while the FIFO was empty.

Behaviour:
- Reset values: lanes 0, fifo read-data register 0, pointers and count 0, pix_vld 0, fifo_empty 1, fifo_full 0, ovf_err 0, udf_err 0.
- Lane update rules (registered; lane[i] takes its new value at the clock edge after cmd is presented):
  - IB: lane[i] <= buf_din[i].
  - SF: lane[i] <= lane[i+1] for i < POY-1; lane[POY-1] <= buf_din[POY-1].
  - IF: lane[i] <= rdata[i] (the FIFO read-data register) for i < POY-1; lane[POY-1] <= buf_din[POY-1].
  - NE: hold.
- Commands are evaluated per lane independently; mixed commands across lanes are legal.
- FIFO entry width is (POY-1)*DW.
- Push: occurs in any cycle where lane 0's command is SF. The pushed entry is the pre-update values of lanes 1..POY-1, packed lane 1 in the LSBs.
- Pop: when fifo_read=1 and the FIFO is not empty, rdata <= head entry and the read pointer advances. rdata is valid the cycle after fifo_read. rdata holds its value until the next successful pop.
- IF in the same cycle as fifo_read uses the old rdata. The producer therefore spaces IF at least one cycle after fifo_read.
- Full: a push while full is dropped (storage and count unchanged) and sets ovf_err. Exception: if a pop also occurs that cycle, the push is accepted and count is unchanged.
- Empty: a pop while empty leaves rdata and pointers unchanged and sets udf_err. A simultaneous push still writes, so count becomes 1.
- Simultaneous push+pop when 0 < count < FDEPTH: both occur and count is unchanged.
- Pointers are log2(FDEPTH) bits and wrap modulo FDEPTH. count is log2(FDEPTH)+1 bits.
- fifo_full and fifo_empty are decoded from count (combinational from registered state).
- pix_vld <= dwpe_ena & (any lane cmd in {IB,SF,IF}). It is therefore high in the same cycle pix_out shows the updated lanes.
- ovf_err and udf_err are cleared only by rst.
- Reset mid-operation: all state returns to reset values on the next edge regardless of cmd/fifo_read. FIFO contents are considered lost, though storage RAM need not be cleared.

Test Plan:
- Reset: hold rst=1 for 2 cycles with cmd=IB and fifo_read=1 -> pix_out=0, pix_vld=0, fifo_empty=1, no errors.
- IB load (POY=3, DW=8): buf_din={8'h33,8'h22,8'h11}, all lanes IB, dwpe_ena=1 -> next cycle pix_out={33,22,11}, pix_vld=1.
- Shift and push: from {33,22,11}, all lanes SF, buf_din lane2=8'h44 -> pix_out={44,33,22}; FIFO count 1 holding entry {33,22}; fifo_empty=0.
- Pop then IF: fifo_read=1 for one cycle, then all lanes IF with buf_din lane2=8'h55 -> pix_out={55,33,22}, count 0, fifo_empty=1.
- Overflow: perform 16 SF pushes -> fifo_full=1. A 17th SF alone -> count stays 16, ovf_err=1. A 17th SF together with fifo_read -> accepted, count stays 16.
- Underflow and mid-op reset: fifo_read on empty with a simultaneous SF -> udf_err=1, count=1. Then assert rst for one cycle -> count 0, udf_err=0, lanes 0.

Source files
------------

// File: rtl/dw_reg_array.sv
`default_nettype none
// ============================================================================
// Module   : dw_reg_array
// Brief    : POY-lane pixel register array feeding the depthwise PE, with a
//            reuse FIFO that keeps overlapping rows for the next window.
// Revision : 1.0 - initial release
// ============================================================================
module dw_reg_array #(
    parameter int DW     = 8,
    parameter int POY    = 3,
    parameter int FDEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [POY*DW-1:0]   buf_din,
    input  logic [2*POY-1:0]    reg_array_cmd,
    input  logic                fifo_read,
    input  logic                dwpe_ena,
    output logic [POY*DW-1:0]   pix_out,
    output logic                pix_vld,
    output logic                fifo_full,
    output logic                fifo_empty,
    output logic                ovf_err,
    output logic                udf_err
);

    localparam int          c_aw      = $clog2(FDEPTH);
    localparam int          c_ew      = (POY - 1) * DW;
    localparam logic [c_aw:0] c_full  = (c_aw + 1)'(FDEPTH);

    localparam logic [1:0]  c_cmd_ib  = 2'b00;
    localparam logic [1:0]  c_cmd_sf  = 2'b01;
    localparam logic [1:0]  c_cmd_if  = 2'b10;

    logic [DW-1:0]      r_lane     [POY];
    logic [DW-1:0]      w_lane_nxt [POY];
    logic [DW-1:0]      w_sf_src   [POY];
    logic [DW-1:0]      w_if_src   [POY];
    logic [c_ew-1:0]    r_mem      [FDEPTH];
    logic [c_ew-1:0]    r_rdata;
    logic [c_ew-1:0]    w_push_data;
    logic [c_aw-1:0]    r_wptr;
    logic [c_aw-1:0]    r_rptr;
    logic [c_aw:0]      r_count;
    logic               r_pix_vld;
    logic               r_ovf_err;
    logic               r_udf_err;
    logic               w_any_upd;
    logic               w_push_req;
    logic               w_push_ok;
    logic               w_pop;

    // Per-lane sources for SF/IF; the top lane always refills from the buffer.
    generate
        for (genvar gi = 0; gi < POY; gi++) begin : g_src
            if (gi < POY - 1) begin : g_inner
                assign w_sf_src[gi] = r_lane[gi+1];
                assign w_if_src[gi] = r_rdata[gi*DW +: DW];
                assign w_push_data[gi*DW +: DW] = r_lane[gi+1];
            end else begin : g_top
                assign w_sf_src[gi] = buf_din[gi*DW +: DW];
                assign w_if_src[gi] = buf_din[gi*DW +: DW];
            end
            assign pix_out[gi*DW +: DW] = r_lane[gi];
        end
    endgenerate

    always_comb begin
        w_any_upd = 1'b0;
        for (int i = 0; i < POY; i++) begin
            w_lane_nxt[i] = r_lane[i];
            case (reg_array_cmd[2*i +: 2])
                c_cmd_ib: w_lane_nxt[i] = buf_din[i*DW +: DW];
                c_cmd_sf: w_lane_nxt[i] = w_sf_src[i];
                c_cmd_if: w_lane_nxt[i] = w_if_src[i];
                default:  w_lane_nxt[i] = r_lane[i];
            endcase
            if (reg_array_cmd[2*i +: 2] != 2'b11) begin
                w_any_upd = 1'b1;
            end
        end
    end

    assign fifo_full  = (r_count == c_full);
    assign fifo_empty = (r_count == '0);

    // A pop that frees a slot lets a push into a full FIFO through.
    assign w_push_req = (reg_array_cmd[1:0] == c_cmd_sf);
    assign w_pop      = fifo_read & ~fifo_empty;
    assign w_push_ok  = w_push_req & (~fifo_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < POY; i++) begin
                r_lane[i] <= '0;
            end
            r_rdata   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_pix_vld <= 1'b0;
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            for (int i = 0; i < POY; i++) begin
                r_lane[i] <= w_lane_nxt[i];
            end
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rdata <= r_mem[r_rptr];
                r_rptr  <= r_rptr + 1'b1;
            end
            r_count   <= r_count + {{c_aw{1'b0}}, w_push_ok} - {{c_aw{1'b0}}, w_pop};
            r_pix_vld <= dwpe_ena & w_any_upd;
            if (w_push_req && !w_push_ok) begin
                r_ovf_err <= 1'b1;
            end
            if (fifo_read && fifo_empty) begin
                r_udf_err <= 1'b1;
            end
        end
    end

    // Storage is not cleared by reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    assign pix_vld = r_pix_vld;
    assign ovf_err = r_ovf_err;
    assign udf_err = r_udf_err;

endmodule
`default_nettype wire

// File: tb/tb_dw_reg_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_dw_reg_array
// Brief    : Self-checking bench for dw_reg_array with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dw_reg_array;

    localparam int DW     = 8;
    localparam int POY    = 3;
    localparam int FDEPTH = 16;
    localparam int EW     = (POY - 1) * DW;

    logic                clk = 1'b0;
    logic                rst;
    logic [POY*DW-1:0]   buf_din;
    logic [2*POY-1:0]    reg_array_cmd;
    logic                fifo_read;
    logic                dwpe_ena;
    logic [POY*DW-1:0]   pix_out;
    logic                pix_vld;
    logic                fifo_full;
    logic                fifo_empty;
    logic                ovf_err;
    logic                udf_err;

    dw_reg_array #(.DW(DW), .POY(POY), .FDEPTH(FDEPTH)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .buf_din       (buf_din),
        .reg_array_cmd (reg_array_cmd),
        .fifo_read     (fifo_read),
        .dwpe_ena      (dwpe_ena),
        .pix_out       (pix_out),
        .pix_vld       (pix_vld),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .ovf_err       (ovf_err),
        .udf_err       (udf_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Behavioural model: lanes as an array, the FIFO as a queue.
    logic [DW-1:0] m_lane [POY];
    logic [EW-1:0] m_q [$];
    logic [EW-1:0] m_rdata = '0;
    logic          m_vld = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    bit            started = 1'b0;

    initial for (int i = 0; i < POY; i++) m_lane[i] = '0;

    always @(posedge clk) begin
        logic [DW-1:0] old_lane [POY];
        logic [EW-1:0] old_rdata;
        logic [EW-1:0] entry;
        logic [1:0]    c;
        int            sz;
        started = 1'b1;
        if (rst) begin
            for (int i = 0; i < POY; i++) m_lane[i] = '0;
            m_q.delete();
            m_rdata = '0;
            m_vld   = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            for (int i = 0; i < POY; i++) old_lane[i] = m_lane[i];
            old_rdata = m_rdata;
            sz = m_q.size();
            for (int j = 0; j < POY - 1; j++) entry[j*DW +: DW] = old_lane[j+1];
            if (fifo_read) begin
                if (sz == 0) m_udf = 1'b1;
                else m_rdata = m_q.pop_front();
            end
            if (reg_array_cmd[1:0] == 2'b01) begin
                if (sz < FDEPTH || (fifo_read && sz > 0)) m_q.push_back(entry);
                else m_ovf = 1'b1;
            end
            m_vld = 1'b0;
            for (int i = 0; i < POY; i++) begin
                c = reg_array_cmd[2*i +: 2];
                if (c != 2'b11) m_vld = dwpe_ena;
                case (c)
                    2'b00: m_lane[i] = buf_din[i*DW +: DW];
                    2'b01: m_lane[i] = (i == POY - 1) ? buf_din[i*DW +: DW] : old_lane[(i + 1) % POY];
                    2'b10: m_lane[i] = (i == POY - 1) ? buf_din[i*DW +: DW] : old_rdata[(i % (POY - 1))*DW +: DW];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [POY*DW-1:0] exp_pix;
        if (started) begin
            for (int i = 0; i < POY; i++) exp_pix[i*DW +: DW] = m_lane[i];
            chk("pix_out", 64'(pix_out), 64'(exp_pix));
            chk("pix_vld", 64'(pix_vld), 64'(m_vld));
            chk("fifo_full", 64'(fifo_full), 64'(m_q.size() == FDEPTH));
            chk("fifo_empty", 64'(fifo_empty), 64'(m_q.size() == 0));
            chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
            chk("udf_err", 64'(udf_err), 64'(m_udf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        buf_din       = 24'hABCDEF;
        reg_array_cmd = 6'b000000;
        fifo_read     = 1'b1;
        dwpe_ena      = 1'b1;
        tick();
        tick();
        chk("rst_pix", 64'(pix_out), 64'h0);
        chk("rst_vld", 64'(pix_vld), 64'h0);
        chk("rst_empty", 64'(fifo_empty), 64'h1);
        chk("rst_err", 64'({ovf_err, udf_err}), 64'h0);

        rst = 1'b0; fifo_read = 1'b0;
        buf_din = 24'h332211; reg_array_cmd = 6'b000000;
        tick();
        chk("ib_pix", 64'(pix_out), 64'h332211);
        chk("ib_vld", 64'(pix_vld), 64'h1);

        buf_din = 24'h440000; reg_array_cmd = 6'b010101;
        tick();
        chk("sf_pix", 64'(pix_out), 64'h443322);
        chk("sf_empty", 64'(fifo_empty), 64'h0);
        chk("sf_model_entry", 64'(m_q[0]), 64'h3322);

        reg_array_cmd = 6'b111111; fifo_read = 1'b1;
        tick();
        chk("ne_vld", 64'(pix_vld), 64'h0);
        fifo_read = 1'b0; buf_din = 24'h550000; reg_array_cmd = 6'b101010;
        tick();
        chk("if_pix", 64'(pix_out), 64'h553322);
        chk("if_empty", 64'(fifo_empty), 64'h1);

        // Mixed per-lane commands, with and without dwpe_ena.
        buf_din = 24'h667788; reg_array_cmd = 6'b011100; dwpe_ena = 1'b0;
        tick();
        chk("mix_pix", 64'(pix_out), 64'h663388);
        chk("mix_vld", 64'(pix_vld), 64'h0);
        dwpe_ena = 1'b1; reg_array_cmd = 6'b111101;
        tick();

        // Fill: one entry already pushed above, fifteen more reach full.
        for (int k = 0; k < FDEPTH - 1; k++) begin
            buf_din = {8'(8'hA0 + k), 16'h0000}; reg_array_cmd = 6'b010101;
            tick();
        end
        chk("full", 64'(fifo_full), 64'h1);
        chk("full_noovf", 64'(ovf_err), 64'h0);
        buf_din = 24'hB00000;
        tick();
        chk("ovf_set", 64'(ovf_err), 64'h1);
        chk("ovf_full", 64'(fifo_full), 64'h1);
        fifo_read = 1'b1; buf_din = 24'hB10000;
        tick();
        chk("full_pushpop", 64'(fifo_full), 64'h1);

        // Drain, including an IF coincident with fifo_read (uses old rdata).
        reg_array_cmd = 6'b111111;
        tick();
        reg_array_cmd = 6'b101010; buf_din = 24'hC00000;
        tick();
        fifo_read = 1'b0;
        tick();
        fifo_read = 1'b1; reg_array_cmd = 6'b111111;
        for (int k = 0; k < FDEPTH - 2; k++) tick();
        fifo_read = 1'b0; reg_array_cmd = 6'b101010; buf_din = 24'hC10000;
        tick();
        chk("drained_empty", 64'(fifo_empty), 64'h1);
        chk("drained_noudf", 64'(udf_err), 64'h0);

        fifo_read = 1'b1; reg_array_cmd = 6'b010101; buf_din = 24'hD00000;
        tick();
        chk("udf_set", 64'(udf_err), 64'h1);
        chk("udf_count1", 64'({fifo_empty, fifo_full}), 64'h0);

        rst = 1'b1; fifo_read = 1'b1;
        tick();
        rst = 1'b0; fifo_read = 1'b0; reg_array_cmd = 6'b111111;
        chk("mrst_empty", 64'(fifo_empty), 64'h1);
        chk("mrst_err", 64'({ovf_err, udf_err}), 64'h0);
        chk("mrst_pix", 64'(pix_out), 64'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
